axi_lite_avalon_bridge: RTL and testbench



---
 rtl/axi_lite_avalon_bridge_if.sv | 66 ++++++
 rtl/axi_lite_avalon_bridge.sv | 191 +++++++++++++++++++
 tb/tb_axi_lite_avalon_bridge.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_avalon_bridge_if.sv
// AXI4-Lite slave channels plus the Avalon-MM master command port of the bridge.
// "slave" is the bridge's view; "master" is the view of whatever drives the AXI side and answers Avalon.
interface axi_lite_avalon_bridge_if #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int AVS_ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]     S_AXI_AWADDR;
    logic [2:0]                S_AXI_AWPROT;
    logic                      S_AXI_AWVALID;
    logic                      S_AXI_AWREADY;
    logic [DATA_WIDTH-1:0]     S_AXI_WDATA;
    logic [DATA_WIDTH/8-1:0]   S_AXI_WSTRB;
    logic                      S_AXI_WVALID;
    logic                      S_AXI_WREADY;
    logic [1:0]                S_AXI_BRESP;
    logic                      S_AXI_BVALID;
    logic                      S_AXI_BREADY;
    logic [ADDR_WIDTH-1:0]     S_AXI_ARADDR;
    logic [2:0]                S_AXI_ARPROT;
    logic                      S_AXI_ARVALID;
    logic                      S_AXI_ARREADY;
    logic [DATA_WIDTH-1:0]     S_AXI_RDATA;
    logic [1:0]                S_AXI_RRESP;
    logic                      S_AXI_RVALID;
    logic                      S_AXI_RREADY;
    logic [AVS_ADDR_WIDTH-1:0] oAvsAddress;
    logic [DATA_WIDTH/8-1:0]   oAvsByteenable;
    logic                      oAvsRead;
    logic                      oAvsWrite;
    logic [DATA_WIDTH-1:0]     oAvsWritedata;
    logic [DATA_WIDTH-1:0]     iAvsReaddata;
    logic                      iAvsWaitrequest;

    // Every channel uses valid/ready: a transfer happens on the rising edge where
    // both are 1; a raised VALID (and its payload) stays put until that edge.
    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_WREADY,
        output S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        output S_AXI_ARREADY,
        output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        input  S_AXI_RREADY,
        output oAvsAddress, oAvsByteenable, oAvsRead, oAvsWrite, oAvsWritedata,
        input  iAvsReaddata, iAvsWaitrequest
    );

    modport master (
        output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        input  S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_WREADY,
        input  S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        output S_AXI_RREADY,
        input  oAvsAddress, oAvsByteenable, oAvsRead, oAvsWrite, oAvsWritedata,
        output iAvsReaddata, iAvsWaitrequest
    );
endinterface

// File: rtl/axi_lite_avalon_bridge.sv
// AXI4-Lite slave to Avalon-MM master bridge: one Avalon transfer per AXI transaction,
// window decode with DECERR, waitrequest handling with SLVERR timeout, fair read/write grant.
module axi_lite_avalon_bridge #(
    parameter int                            C_S_AXI_ADDR_WIDTH = 32,
    parameter int                            C_S_AXI_DATA_WIDTH = 32,
    parameter int                            C_AVS_ADDR_WIDTH   = 32,
    parameter logic [C_S_AXI_ADDR_WIDTH-1:0] C_BASEADDR         = 32'h0000_0000,
    parameter logic [C_S_AXI_ADDR_WIDTH-1:0] C_HIGHADDR         = 32'h0000_FFFF,
    parameter int unsigned                   C_WAIT_TIMEOUT     = 255
) (
    input  logic                          ACLK,
    input  logic                          ARESETN,
    axi_lite_avalon_bridge_if.slave       bus,
    output logic [2:0]                    dbg_state
);
    localparam int AW       = C_S_AXI_ADDR_WIDTH;
    localparam int DW       = C_S_AXI_DATA_WIDTH;
    localparam int VW       = C_AVS_ADDR_WIDTH;
    localparam int SW       = DW / 8;
    localparam int ADDR_LSB = $clog2(SW);
    localparam logic [VW-1:0] LSB_MASK   = VW'((1 << ADDR_LSB) - 1);
    localparam bit            TIMEOUT_EN = (C_WAIT_TIMEOUT != 0);
    localparam logic [31:0]   WAIT_LAST  = 32'(C_WAIT_TIMEOUT - 1);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WR_CAPT = 3'd1;
    localparam logic [2:0] S_WR_AVS  = 3'd2;
    localparam logic [2:0] S_WR_RESP = 3'd3;
    localparam logic [2:0] S_RD_AVS  = 3'd4;
    localparam logic [2:0] S_RD_RESP = 3'd5;

    logic [2:0]    state_q;
    logic          rdy_en_q;
    logic          last_wr_q;
    logic          aw_full_q, w_full_q;
    logic [AW-1:0] aw_addr_q;
    logic [DW-1:0] w_data_q;
    logic [SW-1:0] w_strb_q;
    logic [VW-1:0] avs_addr_q;
    logic [SW-1:0] avs_be_q;
    logic [DW-1:0] avs_wdata_q;
    logic [1:0]    bresp_q, rresp_q;
    logic [DW-1:0] rdata_q;
    logic [31:0]   wait_cnt_q;

    logic          wr_open, ar_ok, rd_grant;
    logic          awready, wready, aw_hs, w_hs, wr_both;
    logic [AW-1:0] wr_addr, wr_off, rd_off;
    logic [DW-1:0] wr_data;
    logic [SW-1:0] wr_strb;
    logic          wr_below, rd_below, wr_in_win, rd_in_win;
    logic [VW-1:0] wr_avs_addr, rd_avs_addr;
    logic          wait_expire;

    // rdy_en_q keeps every READY low while reset is held and for the release cycle.
    assign wr_open  = rdy_en_q && (state_q == S_IDLE || state_q == S_WR_CAPT);
    assign ar_ok    = rdy_en_q && (state_q == S_IDLE) && !aw_full_q && !w_full_q &&
                      (!bus.S_AXI_AWVALID || last_wr_q);
    assign rd_grant = ar_ok && bus.S_AXI_ARVALID;
    assign awready  = wr_open && !aw_full_q && !rd_grant;
    assign wready   = wr_open && !w_full_q && !rd_grant;
    assign aw_hs    = bus.S_AXI_AWVALID && awready;
    assign w_hs     = bus.S_AXI_WVALID && wready;
    assign wr_both  = (aw_full_q || aw_hs) && (w_full_q || w_hs);

    assign wr_addr = aw_full_q ? aw_addr_q : bus.S_AXI_AWADDR;
    assign wr_data = w_full_q ? w_data_q : bus.S_AXI_WDATA;
    assign wr_strb = w_full_q ? w_strb_q : bus.S_AXI_WSTRB;

    // The subtraction borrow doubles as the lower-bound test, so a zero base is not a constant compare.
    assign {wr_below, wr_off} = {1'b0, wr_addr} - {1'b0, C_BASEADDR};
    assign {rd_below, rd_off} = {1'b0, bus.S_AXI_ARADDR} - {1'b0, C_BASEADDR};
    assign wr_in_win   = !wr_below && !(C_HIGHADDR < wr_addr);
    assign rd_in_win   = !rd_below && !(C_HIGHADDR < bus.S_AXI_ARADDR);
    assign wr_avs_addr = wr_off[VW-1:0] & ~LSB_MASK;
    assign rd_avs_addr = rd_off[VW-1:0] & ~LSB_MASK;

    assign wait_expire = TIMEOUT_EN && bus.iAvsWaitrequest && (wait_cnt_q == WAIT_LAST);

    assign bus.S_AXI_AWREADY  = awready;
    assign bus.S_AXI_WREADY   = wready;
    assign bus.S_AXI_ARREADY  = ar_ok;
    assign bus.S_AXI_BVALID   = (state_q == S_WR_RESP);
    assign bus.S_AXI_BRESP    = bresp_q;
    assign bus.S_AXI_RVALID   = (state_q == S_RD_RESP);
    assign bus.S_AXI_RRESP    = rresp_q;
    assign bus.S_AXI_RDATA    = rdata_q;
    assign bus.oAvsWrite      = (state_q == S_WR_AVS);
    assign bus.oAvsRead       = (state_q == S_RD_AVS);
    assign bus.oAvsAddress    = avs_addr_q;
    assign bus.oAvsByteenable = avs_be_q;
    assign bus.oAvsWritedata  = avs_wdata_q;
    assign dbg_state          = state_q;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q     <= S_IDLE;
            rdy_en_q    <= 1'b0;
            last_wr_q   <= 1'b0;
            aw_full_q   <= 1'b0;
            w_full_q    <= 1'b0;
            aw_addr_q   <= '0;
            w_data_q    <= '0;
            w_strb_q    <= '0;
            avs_addr_q  <= '0;
            avs_be_q    <= '0;
            avs_wdata_q <= '0;
            bresp_q     <= RESP_OKAY;
            rresp_q     <= RESP_OKAY;
            rdata_q     <= '0;
            wait_cnt_q  <= '0;
        end else begin
            rdy_en_q <= 1'b1;
            case (state_q)
                S_IDLE, S_WR_CAPT: begin
                    if (rd_grant) begin
                        last_wr_q <= 1'b0;
                        if (rd_in_win) begin
                            state_q    <= S_RD_AVS;
                            avs_addr_q <= rd_avs_addr;
                            avs_be_q   <= '1;
                            wait_cnt_q <= '0;
                        end else begin
                            state_q <= S_RD_RESP;
                            rresp_q <= RESP_DECERR;
                            rdata_q <= '0;
                        end
                    end else begin
                        if (aw_hs || w_hs) last_wr_q <= 1'b1;
                        if (wr_both) begin
                            aw_full_q <= 1'b0;
                            w_full_q  <= 1'b0;
                            if (wr_in_win) begin
                                state_q     <= S_WR_AVS;
                                avs_addr_q  <= wr_avs_addr;
                                avs_be_q    <= wr_strb;
                                avs_wdata_q <= wr_data;
                                wait_cnt_q  <= '0;
                            end else begin
                                state_q <= S_WR_RESP;
                                bresp_q <= RESP_DECERR;
                            end
                        end else begin
                            if (aw_hs) begin
                                aw_full_q <= 1'b1;
                                aw_addr_q <= bus.S_AXI_AWADDR;
                            end
                            if (w_hs) begin
                                w_full_q <= 1'b1;
                                w_data_q <= bus.S_AXI_WDATA;
                                w_strb_q <= bus.S_AXI_WSTRB;
                            end
                            if (aw_hs || w_hs) state_q <= S_WR_CAPT;
                        end
                    end
                end
                S_WR_AVS: begin
                    if (!bus.iAvsWaitrequest) begin
                        state_q <= S_WR_RESP;
                        bresp_q <= RESP_OKAY;
                    end else if (wait_expire) begin
                        state_q <= S_WR_RESP;
                        bresp_q <= RESP_SLVERR;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 32'd1;
                    end
                end
                S_RD_AVS: begin
                    if (!bus.iAvsWaitrequest) begin
                        state_q <= S_RD_RESP;
                        rresp_q <= RESP_OKAY;
                        rdata_q <= bus.iAvsReaddata;
                    end else if (wait_expire) begin
                        state_q <= S_RD_RESP;
                        rresp_q <= RESP_SLVERR;
                        rdata_q <= '0;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 32'd1;
                    end
                end
                S_WR_RESP: if (bus.S_AXI_BREADY) state_q <= S_IDLE;
                S_RD_RESP: if (bus.S_AXI_RREADY) state_q <= S_IDLE;
                default:   state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_lite_avalon_bridge.sv
// Directed bench for axi_lite_avalon_bridge: each task drives one scenario and checks it inline.
module tb_axi_lite_avalon_bridge;
    logic       ACLK    = 1'b0;
    logic       ARESETN = 1'b1;
    logic [2:0] dbg_state;
    int         checks  = 0;
    int         errors  = 0;

    axi_lite_avalon_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .AVS_ADDR_WIDTH(32)) bus ();

    axi_lite_avalon_bridge #(.C_WAIT_TIMEOUT(4)) dut (
        .ACLK      (ACLK),
        .ARESETN   (ARESETN),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 ACLK = ~ACLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge ACLK);
        #1;
    endtask

    task automatic idle_inputs;
        bus.S_AXI_AWADDR    = '0;
        bus.S_AXI_AWPROT    = '0;
        bus.S_AXI_AWVALID   = 1'b0;
        bus.S_AXI_WDATA     = '0;
        bus.S_AXI_WSTRB     = '0;
        bus.S_AXI_WVALID    = 1'b0;
        bus.S_AXI_BREADY    = 1'b1;
        bus.S_AXI_ARADDR    = '0;
        bus.S_AXI_ARPROT    = '0;
        bus.S_AXI_ARVALID   = 1'b0;
        bus.S_AXI_RREADY    = 1'b1;
        bus.iAvsReaddata    = '0;
        bus.iAvsWaitrequest = 1'b0;
    endtask

    task automatic do_reset;
        idle_inputs();
        ARESETN = 1'b0;
        tick();
        tick();
        ARESETN = 1'b1;
        tick();
    endtask

    task automatic wait_bvalid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.S_AXI_BVALID === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_rvalid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.S_AXI_RVALID === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset;
        idle_inputs();
        #2 ARESETN = 1'b0;
        #5;
        checks++;
        if ({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY, bus.S_AXI_BVALID,
             bus.S_AXI_RVALID, bus.oAvsRead, bus.oAvsWrite} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 0000000", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY,
                     bus.S_AXI_ARREADY, bus.S_AXI_BVALID, bus.S_AXI_RVALID, bus.oAvsRead, bus.oAvsWrite});
        end
        checks++;
        if ({bus.oAvsAddress, bus.oAvsByteenable, bus.oAvsWritedata, bus.S_AXI_RDATA,
             bus.S_AXI_BRESP, bus.S_AXI_RRESP, dbg_state} !== '0) begin
            errors++;
            $display("FAIL reset_data: addr=%h be=%h wd=%h rd=%h st=%0d want all 0", bus.oAvsAddress,
                     bus.oAvsByteenable, bus.oAvsWritedata, bus.S_AXI_RDATA, dbg_state);
        end
        tick();
        tick();
        ARESETN = 1'b1;
        tick();
        checks++;
        if ({bus.S_AXI_AWREADY, bus.S_AXI_WREADY} !== 2'b11) begin
            errors++;
            $display("FAIL ready_after_reset: got %b want 11", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY});
        end
    endtask

    task automatic test_write_basic;
        bus.S_AXI_AWADDR  = 32'h10;
        bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WDATA   = 32'hDEAD_BEEF;
        bus.S_AXI_WSTRB   = 4'hF;
        bus.S_AXI_WVALID  = 1'b1;
        #1;
        checks++;
        if ({bus.S_AXI_AWREADY, bus.S_AXI_WREADY} !== 2'b11) begin
            errors++;
            $display("FAIL wr_ready: got %b want 11", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY});
        end
        tick();
        bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WVALID  = 1'b0;
        checks++;
        if (bus.oAvsWrite !== 1'b1 || bus.oAvsAddress !== 32'h10 || bus.oAvsWritedata !== 32'hDEAD_BEEF ||
            bus.oAvsByteenable !== 4'hF || bus.S_AXI_BVALID !== 1'b0) begin
            errors++;
            $display("FAIL wr_cmd_t1: wr=%b addr=%h wd=%h be=%h bv=%b want 1 10 deadbeef f 0", bus.oAvsWrite,
                     bus.oAvsAddress, bus.oAvsWritedata, bus.oAvsByteenable, bus.S_AXI_BVALID);
        end
        tick();
        checks++;
        if (bus.oAvsWrite !== 1'b0 || bus.S_AXI_BVALID !== 1'b1 || bus.S_AXI_BRESP !== 2'b00) begin
            errors++;
            $display("FAIL wr_resp_t2: wr=%b bv=%b bresp=%b want 0 1 00", bus.oAvsWrite, bus.S_AXI_BVALID,
                     bus.S_AXI_BRESP);
        end
        tick();
        checks++;
        if (bus.S_AXI_BVALID !== 1'b0 || dbg_state !== 3'd0) begin
            errors++;
            $display("FAIL wr_done: bv=%b state=%0d want 0 0", bus.S_AXI_BVALID, dbg_state);
        end
    endtask

    task automatic test_w_before_aw;
        int n;
        bus.S_AXI_WDATA  = 32'hCAFE_F00D;
        bus.S_AXI_WSTRB  = 4'h3;
        bus.S_AXI_WVALID = 1'b1;
        #1;
        checks++;
        if (bus.S_AXI_WREADY !== 1'b1) begin
            errors++;
            $display("FAIL w_first_ready: got %b want 1", bus.S_AXI_WREADY);
        end
        tick();
        bus.S_AXI_WVALID = 1'b0;
        checks++;
        if (dbg_state !== 3'd1 || bus.S_AXI_WREADY !== 1'b0 || bus.S_AXI_AWREADY !== 1'b1 ||
            bus.oAvsWrite !== 1'b0) begin
            errors++;
            $display("FAIL w_capt: state=%0d wready=%b awready=%b wr=%b want 1 0 1 0", dbg_state,
                     bus.S_AXI_WREADY, bus.S_AXI_AWREADY, bus.oAvsWrite);
        end
        tick();
        tick();
        bus.S_AXI_AWADDR    = 32'h44;
        bus.S_AXI_AWVALID   = 1'b1;
        bus.iAvsWaitrequest = 1'b1;
        tick();
        bus.S_AXI_AWVALID = 1'b0;
        n = 0;
        for (int k = 0; k < 4; k++) begin
            bus.iAvsWaitrequest = (k < 3);
            #1;
            if (bus.oAvsWrite === 1'b1 && bus.oAvsAddress === 32'h44 &&
                bus.oAvsWritedata === 32'hCAFE_F00D && bus.oAvsByteenable === 4'h3) n++;
            tick();
        end
        checks++;
        if (n !== 4) begin
            errors++;
            $display("FAIL wait_hold: stable write cycles got %0d want 4", n);
        end
        checks++;
        if (bus.oAvsWrite !== 1'b0 || bus.S_AXI_BVALID !== 1'b1 || bus.S_AXI_BRESP !== 2'b00) begin
            errors++;
            $display("FAIL wait_resp: wr=%b bv=%b bresp=%b want 0 1 00", bus.oAvsWrite, bus.S_AXI_BVALID,
                     bus.S_AXI_BRESP);
        end
        tick();
        checks++;
        if (bus.S_AXI_BVALID !== 1'b0) begin
            errors++;
            $display("FAIL wait_done: bv=%b want 0", bus.S_AXI_BVALID);
        end
    endtask

    task automatic test_read_backpressure;
        int n;
        bus.S_AXI_RREADY  = 1'b0;
        bus.S_AXI_ARADDR  = 32'h20;
        bus.S_AXI_ARVALID = 1'b1;
        #1;
        checks++;
        if ({bus.S_AXI_ARREADY, bus.S_AXI_AWREADY, bus.S_AXI_WREADY} !== 3'b100) begin
            errors++;
            $display("FAIL rd_grant: ar/aw/w ready got %b want 100", {bus.S_AXI_ARREADY,
                     bus.S_AXI_AWREADY, bus.S_AXI_WREADY});
        end
        tick();
        bus.S_AXI_ARVALID = 1'b0;
        bus.iAvsReaddata  = 32'h1234_5678;
        checks++;
        if (bus.oAvsRead !== 1'b1 || bus.oAvsWrite !== 1'b0 || bus.oAvsAddress !== 32'h20 ||
            bus.oAvsByteenable !== 4'hF) begin
            errors++;
            $display("FAIL rd_cmd: rd=%b wr=%b addr=%h be=%h want 1 0 20 f", bus.oAvsRead, bus.oAvsWrite,
                     bus.oAvsAddress, bus.oAvsByteenable);
        end
        tick();
        bus.iAvsReaddata = 32'hFFFF_FFFF;
        checks++;
        if (bus.S_AXI_RVALID !== 1'b1 || bus.S_AXI_RDATA !== 32'h1234_5678 || bus.S_AXI_RRESP !== 2'b00 ||
            bus.oAvsRead !== 1'b0) begin
            errors++;
            $display("FAIL rd_resp: rv=%b rdata=%h rresp=%b rd=%b want 1 12345678 00 0", bus.S_AXI_RVALID,
                     bus.S_AXI_RDATA, bus.S_AXI_RRESP, bus.oAvsRead);
        end
        n = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (bus.S_AXI_RVALID === 1'b1 && bus.S_AXI_RDATA === 32'h1234_5678 &&
                bus.S_AXI_RRESP === 2'b00) n++;
        end
        checks++;
        if (n !== 5) begin
            errors++;
            $display("FAIL rd_hold: stable response cycles got %0d want 5", n);
        end
        bus.S_AXI_RREADY = 1'b1;
        tick();
        checks++;
        if (bus.S_AXI_RVALID !== 1'b0 || dbg_state !== 3'd0) begin
            errors++;
            $display("FAIL rd_done: rv=%b state=%0d want 0 0", bus.S_AXI_RVALID, dbg_state);
        end
    endtask

    task automatic test_out_of_window;
        bus.S_AXI_AWADDR  = 32'h0001_0000;
        bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WDATA   = 32'h5555_AAAA;
        bus.S_AXI_WSTRB   = 4'hF;
        bus.S_AXI_WVALID  = 1'b1;
        tick();
        bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WVALID  = 1'b0;
        checks++;
        if (bus.oAvsWrite !== 1'b0 || bus.S_AXI_BVALID !== 1'b1 || bus.S_AXI_BRESP !== 2'b11) begin
            errors++;
            $display("FAIL wr_decerr: wr=%b bv=%b bresp=%b want 0 1 11", bus.oAvsWrite, bus.S_AXI_BVALID,
                     bus.S_AXI_BRESP);
        end
        tick();
        bus.S_AXI_ARADDR  = 32'h0002_0000;
        bus.S_AXI_ARVALID = 1'b1;
        tick();
        bus.S_AXI_ARVALID = 1'b0;
        checks++;
        if (bus.oAvsRead !== 1'b0 || bus.S_AXI_RVALID !== 1'b1 || bus.S_AXI_RRESP !== 2'b11 ||
            bus.S_AXI_RDATA !== 32'h0) begin
            errors++;
            $display("FAIL rd_decerr: rd=%b rv=%b rresp=%b rdata=%h want 0 1 11 0", bus.oAvsRead,
                     bus.S_AXI_RVALID, bus.S_AXI_RRESP, bus.S_AXI_RDATA);
        end
        tick();
        checks++;
        if (bus.S_AXI_RVALID !== 1'b0 || bus.S_AXI_BVALID !== 1'b0) begin
            errors++;
            $display("FAIL decerr_done: rv=%b bv=%b want 0 0", bus.S_AXI_RVALID, bus.S_AXI_BVALID);
        end
    endtask

    task automatic test_arbitration;
        bit ok;
        bit exp_wr;
        do_reset();
        bus.iAvsReaddata = 32'hA5A5_A5A5;
        for (int r = 0; r < 4; r++) begin
            exp_wr = (r % 2 == 0);
            bus.S_AXI_AWADDR  = 32'h100 + 32'(r * 4);
            bus.S_AXI_AWVALID = 1'b1;
            bus.S_AXI_WDATA   = 32'(r);
            bus.S_AXI_WSTRB   = 4'hF;
            bus.S_AXI_WVALID  = 1'b1;
            bus.S_AXI_ARADDR  = 32'h200;
            bus.S_AXI_ARVALID = 1'b1;
            #1;
            checks++;
            if ({bus.S_AXI_AWREADY, bus.S_AXI_ARREADY} !== {exp_wr, !exp_wr}) begin
                errors++;
                $display("FAIL tie_grant_%0d: aw/ar ready got %b want %b", r,
                         {bus.S_AXI_AWREADY, bus.S_AXI_ARREADY}, {exp_wr, !exp_wr});
            end
            tick();
            bus.S_AXI_AWVALID = 1'b0;
            bus.S_AXI_WVALID  = 1'b0;
            bus.S_AXI_ARVALID = 1'b0;
            checks++;
            if ({bus.oAvsWrite, bus.oAvsRead} !== {exp_wr, !exp_wr}) begin
                errors++;
                $display("FAIL tie_cmd_%0d: wr/rd got %b want %b", r, {bus.oAvsWrite, bus.oAvsRead},
                         {exp_wr, !exp_wr});
            end
            if (exp_wr) wait_bvalid(ok);
            else        wait_rvalid(ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL tie_resp_%0d: no response within 20 cycles", r);
            end
            tick();
        end
    endtask

    task automatic test_timeout;
        int n;
        bus.iAvsWaitrequest = 1'b1;
        bus.S_AXI_ARADDR    = 32'h30;
        bus.S_AXI_ARVALID   = 1'b1;
        tick();
        bus.S_AXI_ARVALID = 1'b0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.oAvsRead !== 1'b1) break;
            n++;
            tick();
        end
        checks++;
        if (n !== 4) begin
            errors++;
            $display("FAIL timeout_len: oAvsRead cycles got %0d want 4", n);
        end
        checks++;
        if (bus.S_AXI_RVALID !== 1'b1 || bus.S_AXI_RRESP !== 2'b10 || bus.S_AXI_RDATA !== 32'h0) begin
            errors++;
            $display("FAIL timeout_resp: rv=%b rresp=%b rdata=%h want 1 10 0", bus.S_AXI_RVALID,
                     bus.S_AXI_RRESP, bus.S_AXI_RDATA);
        end
        bus.iAvsWaitrequest = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_transfer;
        int n;
        bus.iAvsWaitrequest = 1'b1;
        bus.S_AXI_AWADDR    = 32'h40;
        bus.S_AXI_AWVALID   = 1'b1;
        bus.S_AXI_WDATA     = 32'h1122_3344;
        bus.S_AXI_WSTRB     = 4'hF;
        bus.S_AXI_WVALID    = 1'b1;
        tick();
        bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WVALID  = 1'b0;
        checks++;
        if (bus.oAvsWrite !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre: wr=%b want 1", bus.oAvsWrite);
        end
        #2 ARESETN = 1'b0;
        #1;
        checks++;
        if ({bus.oAvsWrite, bus.oAvsRead, bus.S_AXI_BVALID, bus.S_AXI_RVALID, bus.S_AXI_AWREADY,
             bus.S_AXI_WREADY, bus.S_AXI_ARREADY} !== 7'b0 || bus.oAvsAddress !== 32'h0 ||
            bus.oAvsWritedata !== 32'h0 || bus.oAvsByteenable !== 4'h0 || dbg_state !== 3'd0) begin
            errors++;
            $display("FAIL mid_reset: wr=%b bv=%b addr=%h wd=%h be=%h st=%0d want all 0", bus.oAvsWrite,
                     bus.S_AXI_BVALID, bus.oAvsAddress, bus.oAvsWritedata, bus.oAvsByteenable, dbg_state);
        end
        tick();
        tick();
        ARESETN = 1'b1;
        bus.iAvsWaitrequest = 1'b0;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.S_AXI_BVALID !== 1'b0 || bus.oAvsWrite !== 1'b0) n++;
        end
        checks++;
        if (n !== 0) begin
            errors++;
            $display("FAIL mid_no_resp: stray BVALID/oAvsWrite cycles got %0d want 0", n);
        end
        checks++;
        if (bus.S_AXI_AWREADY !== 1'b1 || dbg_state !== 3'd0) begin
            errors++;
            $display("FAIL mid_idle: awready=%b state=%0d want 1 0", bus.S_AXI_AWREADY, dbg_state);
        end
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_w_before_aw();
        test_read_backpressure();
        test_out_of_window();
        test_arbitration();
        test_timeout();
        test_reset_mid_transfer();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
